// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory-side request/response bus between the instruction fetch
// side (f*) and the data access side (m*). Request pulses are latched per
// side, granted round-robin, and only one transaction is outstanding at a
// time. The bus response is routed back to the side that owns the
// transaction. A transaction that sees no response within TIMEOUT_CYCLES is
// aborted with a timeout-qualified response carrying zero data.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   fetch_request_enable      one-cycle fetch request pulse
//   freq_mode/addr/wdata/wstrb fetch request fields (mode 0=read, 1=write)
//   fetch_response_enable     one-cycle response pulse to fetch
//   fresp_data, fetch_timeout fetch response data and abort qualifier
//   mem_request_enable        one-cycle data-side request pulse
//   mreq_mode/addr/wdata/wstrb data-side request fields
//   mem_response_enable       one-cycle response pulse to the data side
//   mresp_data, mem_timeout   data-side response data and abort qualifier
//   request_enable            one-cycle request pulse to the bus
//   req_mode/addr/wdata/wstrb registered request fields, held until next grant
//   response_enable, resp_data bus response pulse and read data
//   protocol_error            sticky: duplicate request or stray response
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  output logic        fetch_timeout,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        mem_timeout,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        protocol_error
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic SIDE_F = 1'b0;
  localparam logic SIDE_M = 1'b1;

  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // FSM and transaction bookkeeping
  state_t           r_state;
  logic             r_owner;
  logic             r_lastGrant;
  logic             r_justAborted;
  logic [CNT_W-1:0] r_cnt;

  // Per-side pending latches
  logic        r_fPend, r_fMode;
  logic [31:0] r_fAddr, r_fWdata;
  logic [3:0]  r_fWstrb;
  logic        r_mPend, r_mMode;
  logic [31:0] r_mAddr, r_mWdata;
  logic [3:0]  r_mWstrb;

  // Registered outputs
  logic        r_reqEn, r_reqMode;
  logic [31:0] r_reqAddr, r_reqWdata;
  logic [3:0]  r_reqWstrb;
  logic        r_fRespEn, r_fTimeout;
  logic [31:0] r_fRespData;
  logic        r_mRespEn, r_mTimeout;
  logic [31:0] r_mRespData;
  logic        r_protErr;

  // Combinational decode
  logic        w_respValid, w_timeoutHit, w_done;
  logic        w_fInFlight, w_mInFlight;
  logic        w_fBusy, w_mBusy;
  logic        w_fAccept, w_mAccept;
  logic        w_fDup, w_mDup;
  logic        w_fReq, w_mReq;
  logic        w_fSelMode, w_mSelMode;
  logic [31:0] w_fSelAddr, w_fSelWdata, w_mSelAddr, w_mSelWdata;
  logic [3:0]  w_fSelWstrb, w_mSelWstrb;
  logic        w_grantValid, w_grantSide;

  // Next-state values
  state_t           w_nxtState;
  logic             w_nxtOwner, w_nxtLastGrant, w_nxtJustAborted;
  logic [CNT_W-1:0] w_nxtCnt;
  logic             w_nxtReqEn, w_nxtReqMode;
  logic [31:0]      w_nxtReqAddr, w_nxtReqWdata;
  logic [3:0]       w_nxtReqWstrb;
  logic             w_nxtFRespEn, w_nxtFTimeout;
  logic [31:0]      w_nxtFRespData;
  logic             w_nxtMRespEn, w_nxtMTimeout;
  logic [31:0]      w_nxtMRespData;
  logic             w_nxtFPend, w_nxtMPend;
  logic             w_nxtProtErr;

  // A response is only honoured in WAIT, and not in the cycle right after a
  // timeout abort: a late reply to the aborted transaction must never be
  // mistaken for the reply to a freshly granted one.
  assign w_respValid  = response_enable && (r_state == S_WAIT) && !r_justAborted;

  // The cycle in which the request is on the bus is not counted, so the
  // abort lands TIMEOUT_CYCLES full cycles after the request pulse. A real
  // response in the same cycle takes priority over the abort.
  assign w_timeoutHit = TO_EN && (r_state == S_WAIT) && !r_reqEn &&
                        (r_cnt == TO_LAST) && !w_respValid;
  assign w_done       = w_respValid || w_timeoutHit;

  // A side's slot frees in the completing cycle, so the owner may re-request
  // in the same cycle as its response arrives.
  assign w_fInFlight = (r_state == S_WAIT) && (r_owner == SIDE_F) && !w_done;
  assign w_mInFlight = (r_state == S_WAIT) && (r_owner == SIDE_M) && !w_done;
  assign w_fBusy     = r_fPend || w_fInFlight;
  assign w_mBusy     = r_mPend || w_mInFlight;
  assign w_fAccept   = fetch_request_enable && !w_fBusy;
  assign w_mAccept   = mem_request_enable && !w_mBusy;
  assign w_fDup      = fetch_request_enable && w_fBusy;
  assign w_mDup      = mem_request_enable && w_mBusy;
  assign w_fReq      = r_fPend || w_fAccept;
  assign w_mReq      = r_mPend || w_mAccept;

  // Grant source is the latch if one is held, else the same-cycle pulse.
  assign w_fSelMode  = r_fPend ? r_fMode  : freq_mode;
  assign w_fSelAddr  = r_fPend ? r_fAddr  : freq_addr;
  assign w_fSelWdata = r_fPend ? r_fWdata : freq_wdata;
  assign w_fSelWstrb = r_fPend ? r_fWstrb : freq_wstrb;
  assign w_mSelMode  = r_mPend ? r_mMode  : mreq_mode;
  assign w_mSelAddr  = r_mPend ? r_mAddr  : mreq_addr;
  assign w_mSelWdata = r_mPend ? r_mWdata : mreq_wdata;
  assign w_mSelWstrb = r_mPend ? r_mWstrb : mreq_wstrb;

  // Round-robin: on contention the side that did not win last time goes.
  assign w_grantValid = ((r_state == S_IDLE) || w_done) && (w_fReq || w_mReq);
  assign w_grantSide  = (w_fReq && w_mReq) ? ~r_lastGrant : w_mReq;

  // Next-state, grant and response generation
  always_comb begin
    w_nxtState       = r_state;
    w_nxtOwner       = r_owner;
    w_nxtLastGrant   = r_lastGrant;
    w_nxtJustAborted = w_timeoutHit;
    w_nxtCnt         = r_cnt;
    w_nxtReqEn       = 1'b0;
    w_nxtReqMode     = r_reqMode;
    w_nxtReqAddr     = r_reqAddr;
    w_nxtReqWdata    = r_reqWdata;
    w_nxtReqWstrb    = r_reqWstrb;
    w_nxtFRespEn     = 1'b0;
    w_nxtFTimeout    = 1'b0;
    w_nxtFRespData   = 32'd0;
    w_nxtMRespEn     = 1'b0;
    w_nxtMTimeout    = 1'b0;
    w_nxtMRespData   = 32'd0;
    w_nxtFPend       = r_fPend || w_fAccept;
    w_nxtMPend       = r_mPend || w_mAccept;
    w_nxtProtErr     = r_protErr || w_fDup || w_mDup ||
                       (response_enable && !w_respValid);

    case (r_state)
      S_IDLE: begin
        w_nxtCnt = '0;
      end
      S_WAIT: begin
        if (w_done) begin
          w_nxtState = S_IDLE;
          w_nxtCnt   = '0;
        end else if (!r_reqEn) begin
          w_nxtCnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nxtState = S_IDLE;
        w_nxtCnt   = '0;
      end
    endcase

    if (w_done) begin
      if (r_owner == SIDE_F) begin
        w_nxtFRespEn   = 1'b1;
        w_nxtFTimeout  = w_timeoutHit;
        w_nxtFRespData = w_respValid ? resp_data : 32'd0;
      end else begin
        w_nxtMRespEn   = 1'b1;
        w_nxtMTimeout  = w_timeoutHit;
        w_nxtMRespData = w_respValid ? resp_data : 32'd0;
      end
    end

    if (w_grantValid) begin
      w_nxtState     = S_WAIT;
      w_nxtCnt       = '0;
      w_nxtOwner     = w_grantSide;
      w_nxtLastGrant = w_grantSide;
      w_nxtReqEn     = 1'b1;
      if (w_grantSide == SIDE_M) begin
        w_nxtReqMode  = w_mSelMode;
        w_nxtReqAddr  = w_mSelAddr;
        w_nxtReqWdata = w_mSelWdata;
        w_nxtReqWstrb = w_mSelWstrb;
        w_nxtMPend    = 1'b0;
      end else begin
        w_nxtReqMode  = w_fSelMode;
        w_nxtReqAddr  = w_fSelAddr;
        w_nxtReqWdata = w_fSelWdata;
        w_nxtReqWstrb = w_fSelWstrb;
        w_nxtFPend    = 1'b0;
      end
    end
  end

  // FSM state register; last grant resets to fetch so data wins first
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_owner       <= SIDE_F;
      r_lastGrant   <= SIDE_F;
      r_justAborted <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_nxtState;
      r_owner       <= w_nxtOwner;
      r_lastGrant   <= w_nxtLastGrant;
      r_justAborted <= w_nxtJustAborted;
      r_cnt         <= w_nxtCnt;
    end
  end

  // Pending latches capture fields only when a pulse is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fPend  <= 1'b0;
      r_fMode  <= 1'b0;
      r_fAddr  <= 32'd0;
      r_fWdata <= 32'd0;
      r_fWstrb <= 4'd0;
      r_mPend  <= 1'b0;
      r_mMode  <= 1'b0;
      r_mAddr  <= 32'd0;
      r_mWdata <= 32'd0;
      r_mWstrb <= 4'd0;
    end else begin
      r_fPend <= w_nxtFPend;
      r_mPend <= w_nxtMPend;
      if (w_fAccept) begin
        r_fMode  <= freq_mode;
        r_fAddr  <= freq_addr;
        r_fWdata <= freq_wdata;
        r_fWstrb <= freq_wstrb;
      end
      if (w_mAccept) begin
        r_mMode  <= mreq_mode;
        r_mAddr  <= mreq_addr;
        r_mWdata <= mreq_wdata;
        r_mWstrb <= mreq_wstrb;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_reqEn     <= 1'b0;
      r_reqMode   <= 1'b0;
      r_reqAddr   <= 32'd0;
      r_reqWdata  <= 32'd0;
      r_reqWstrb  <= 4'd0;
      r_fRespEn   <= 1'b0;
      r_fTimeout  <= 1'b0;
      r_fRespData <= 32'd0;
      r_mRespEn   <= 1'b0;
      r_mTimeout  <= 1'b0;
      r_mRespData <= 32'd0;
      r_protErr   <= 1'b0;
    end else begin
      r_reqEn     <= w_nxtReqEn;
      r_reqMode   <= w_nxtReqMode;
      r_reqAddr   <= w_nxtReqAddr;
      r_reqWdata  <= w_nxtReqWdata;
      r_reqWstrb  <= w_nxtReqWstrb;
      r_fRespEn   <= w_nxtFRespEn;
      r_fTimeout  <= w_nxtFTimeout;
      r_fRespData <= w_nxtFRespData;
      r_mRespEn   <= w_nxtMRespEn;
      r_mTimeout  <= w_nxtMTimeout;
      r_mRespData <= w_nxtMRespData;
      r_protErr   <= w_nxtProtErr;
    end
  end

  assign request_enable        = r_reqEn;
  assign req_mode              = r_reqMode;
  assign req_addr              = r_reqAddr;
  assign req_wdata             = r_reqWdata;
  assign req_wstrb             = r_reqWstrb;
  assign fetch_response_enable = r_fRespEn;
  assign fresp_data            = r_fRespData;
  assign fetch_timeout         = r_fTimeout;
  assign mem_response_enable   = r_mRespEn;
  assign mresp_data            = r_mRespData;
  assign mem_timeout           = r_mTimeout;
  assign protocol_error        = r_protErr;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed stimulus for mem_bus_arbiter with a scoreboard. The stimulus
// thread pushes every expected bus request and every expected response
// (including the cycle it must appear in) into queues; a monitor on the
// falling edge pops and compares whenever the DUT pulses an output.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_request_enable, freq_mode;
  logic [31:0] freq_addr, freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable, fetch_timeout;
  logic [31:0] fresp_data;
  logic        mem_request_enable, mreq_mode;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable, mem_timeout;
  logic [31:0] mresp_data;
  logic        request_enable, req_mode;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        protocol_error;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(11)) dut (
    .clk(clk), .rstn(rstn),
    .fetch_request_enable(fetch_request_enable), .freq_mode(freq_mode),
    .freq_addr(freq_addr), .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
    .fetch_response_enable(fetch_response_enable), .fresp_data(fresp_data),
    .fetch_timeout(fetch_timeout),
    .mem_request_enable(mem_request_enable), .mreq_mode(mreq_mode),
    .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mem_response_enable(mem_response_enable), .mresp_data(mresp_data),
    .mem_timeout(mem_timeout),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reqExp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        to;
  } respExp_t;

  reqExp_t  qReq[$];
  respExp_t qF[$];
  respExp_t qM[$];
  reqExp_t  monReq;
  respExp_t monResp;

  // Last request fields issued per side (index 0 = fetch, 1 = mem)
  logic        sMode[2];
  logic [31:0] sAddr[2];
  logic [31:0] sWdata[2];
  logic [3:0]  sWstrb[2];

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic side, input logic mode,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb);
    if (side == 1'b0) begin
      fetch_request_enable = 1'b1;
      freq_mode = mode; freq_addr = addr; freq_wdata = wdata; freq_wstrb = wstrb;
    end else begin
      mem_request_enable = 1'b1;
      mreq_mode = mode; mreq_addr = addr; mreq_wdata = wdata; mreq_wstrb = wstrb;
    end
    sMode[side] = mode; sAddr[side] = addr; sWdata[side] = wdata; sWstrb[side] = wstrb;
  endtask

  task automatic applyResponse(input logic [31:0] d);
    response_enable = 1'b1;
    resp_data = d;
  endtask

  task automatic pushReq(input int c, input logic side);
    reqExp_t e;
    e.cyc = c; e.mode = sMode[side]; e.addr = sAddr[side];
    e.wdata = sWdata[side]; e.wstrb = sWstrb[side];
    qReq.push_back(e);
  endtask

  task automatic pushResp(input int c, input logic side, input logic [31:0] d,
                          input logic to);
    respExp_t e;
    e.cyc = c; e.data = d; e.to = to;
    if (side == 1'b0) qF.push_back(e);
    else              qM.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      fetch_request_enable = 1'b0;
      mem_request_enable   = 1'b0;
      response_enable      = 1'b0;
    end
  endtask

  task automatic clearInputs();
    fetch_request_enable = 0; freq_mode = 0; freq_addr = 0; freq_wdata = 0; freq_wstrb = 0;
    mem_request_enable = 0; mreq_mode = 0; mreq_addr = 0; mreq_wdata = 0; mreq_wstrb = 0;
    response_enable = 0; resp_data = 0;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    clearInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " request_enable"}, 32'(request_enable), 0);
    checkOutput({tag, " req_mode"}, 32'(req_mode), 0);
    checkOutput({tag, " req_addr"}, req_addr, 0);
    checkOutput({tag, " req_wdata"}, req_wdata, 0);
    checkOutput({tag, " req_wstrb"}, 32'(req_wstrb), 0);
    checkOutput({tag, " fetch_response_enable"}, 32'(fetch_response_enable), 0);
    checkOutput({tag, " fresp_data"}, fresp_data, 0);
    checkOutput({tag, " fetch_timeout"}, 32'(fetch_timeout), 0);
    checkOutput({tag, " mem_response_enable"}, 32'(mem_response_enable), 0);
    checkOutput({tag, " mresp_data"}, mresp_data, 0);
    checkOutput({tag, " mem_timeout"}, 32'(mem_timeout), 0);
    checkOutput({tag, " protocol_error"}, 32'(protocol_error), 0);
  endtask

  // Monitor: compare every pulse the DUT presents against the scoreboard
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (request_enable) begin
        if (qReq.size() == 0) begin
          checkOutput("unexpected request_enable", 32'(request_enable), 0);
        end else begin
          monReq = qReq.pop_front();
          checkOutput("req cycle", 32'(cyc), 32'(monReq.cyc));
          checkOutput("req_mode", 32'(req_mode), 32'(monReq.mode));
          checkOutput("req_addr", req_addr, monReq.addr);
          checkOutput("req_wdata", req_wdata, monReq.wdata);
          checkOutput("req_wstrb", 32'(req_wstrb), 32'(monReq.wstrb));
        end
      end
      if (fetch_response_enable) begin
        if (qF.size() == 0) begin
          checkOutput("unexpected fetch_response_enable", 32'(fetch_response_enable), 0);
        end else begin
          monResp = qF.pop_front();
          checkOutput("fresp cycle", 32'(cyc), 32'(monResp.cyc));
          checkOutput("fresp_data", fresp_data, monResp.data);
          checkOutput("fetch_timeout", 32'(fetch_timeout), 32'(monResp.to));
        end
      end
      if (mem_response_enable) begin
        if (qM.size() == 0) begin
          checkOutput("unexpected mem_response_enable", 32'(mem_response_enable), 0);
        end else begin
          monResp = qM.pop_front();
          checkOutput("mresp cycle", 32'(cyc), 32'(monResp.cyc));
          checkOutput("mresp_data", mresp_data, monResp.data);
          checkOutput("mem_timeout", 32'(mem_timeout), 32'(monResp.to));
        end
      end
    end
  end

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    logic owner;
    rstn = 1'b0;
    clearInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAllZero("reset");
    rstn = 1'b1;
    step(1);

    // 1. single fetch read
    c = cyc;
    applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    pushReq(c + 1, 1'b0);
    step(5);
    applyResponse(32'hDEAD_BEEF);
    pushResp(c + 6, 1'b0, 32'hDEAD_BEEF, 1'b0);
    step(4);
    checkOutput("t1 protocol_error", 32'(protocol_error), 0);

    // 2. simultaneous requests after reset: data side first
    doReset();
    c = cyc;
    applyStimulus(1'b0, 1'b0, 32'h0000_0200, 32'hAAAA_0000, 4'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF);
    pushReq(c + 1, 1'b1);
    step(3);
    applyResponse(32'h1111_1111);
    pushResp(c + 4, 1'b1, 32'h1111_1111, 1'b0);
    pushReq(c + 4, 1'b0);
    step(3);
    applyResponse(32'h2222_2222);
    pushResp(c + 7, 1'b0, 32'h2222_2222, 1'b0);
    step(3);

    // 3. alternation: owner re-requests in its response cycle, M,F,M,F,M,F
    c = cyc;
    applyStimulus(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_2000, 32'h2000_0000, 4'h3);
    pushReq(c + 1, 1'b1);
    step(3);
    for (int i = 0; i < 6; i++) begin
      c = cyc;
      owner = (i % 2 == 0) ? 1'b1 : 1'b0;
      applyResponse(32'h5000_0000 + 32'(i));
      pushResp(c + 1, owner, 32'h5000_0000 + 32'(i), 1'b0);
      if (i < 5) pushReq(c + 1, ~owner);
      if (i < 4) begin
        if (owner)
          applyStimulus(1'b1, 1'b1, 32'h0000_2000 + 32'(16 * (i + 1)),
                        32'h2000_0000 + 32'(i + 1), 4'hC);
        else
          applyStimulus(1'b0, 1'b0, 32'h0000_1000 + 32'(16 * (i + 1)), 32'h0, 4'h0);
      end
      step(3);
    end
    checkOutput("t3 protocol_error", 32'(protocol_error), 0);

    // 4. duplicate request while in flight
    c = cyc;
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    pushReq(c + 1, 1'b1);
    step(2);
    applyStimulus(1'b1, 1'b1, 32'h0000_0404, 32'h0000_0099, 4'hF);
    step(1);
    checkOutput("t4 protocol_error set", 32'(protocol_error), 1);
    step(1);
    c = cyc;
    applyResponse(32'h4444_4444);
    pushResp(c + 1, 1'b1, 32'h4444_4444, 1'b0);
    step(4);
    checkOutput("t4 protocol_error sticky", 32'(protocol_error), 1);

    // 5. timeout abort, then a late response in the cycle after the abort
    doReset();
    checkOutput("t5 protocol_error after reset", 32'(protocol_error), 0);
    c = cyc;
    applyStimulus(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    pushReq(c + 1, 1'b0);
    step(3);
    applyStimulus(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
    pushResp(c + 10, 1'b0, 32'h0, 1'b1);
    pushReq(c + 10, 1'b1);
    step(7);
    checkOutput("t5 protocol_error before stray", 32'(protocol_error), 0);
    applyResponse(32'hBAD0_BAD0);
    step(1);
    checkOutput("t5 protocol_error after stray", 32'(protocol_error), 1);
    step(1);
    applyResponse(32'h6666_6666);
    pushResp(c + 13, 1'b1, 32'h6666_6666, 1'b0);
    step(3);

    // 6. asynchronous reset in the middle of WAIT
    c = cyc;
    applyStimulus(1'b1, 1'b1, 32'h0000_0700, 32'h7777_7777, 4'h5);
    pushReq(c + 1, 1'b1);
    step(2);
    checkOutput("t6 req_addr before reset", req_addr, 32'h0000_0700);
    #1;
    rstn = 1'b0;
    #1;
    checkAllZero("async reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    c = cyc;
    applyStimulus(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'h0);
    pushReq(c + 1, 1'b1);
    step(3);
    applyResponse(32'h8888_8888);
    pushResp(c + 4, 1'b1, 32'h8888_8888, 1'b0);
    step(3);
    checkOutput("t6 protocol_error clean", 32'(protocol_error), 0);
    applyResponse(32'h0000_0001);
    step(2);
    checkOutput("t6 stray in IDLE", 32'(protocol_error), 1);
    step(2);

    checkOutput("request queue drained", 32'(qReq.size()), 0);
    checkOutput("fetch response queue drained", 32'(qF.size()), 0);
    checkOutput("mem response queue drained", 32'(qM.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
